// File: rtl/lcd_instr_sequencer.sv
// Purpose: HD44780 8-bit power-on init sequencer plus host instruction FIFO feeding the LCD PHY.
// Latency: a push into an empty FIFO in RUN shows on phy_valid_o/phy_instr_o the next cycle.
// Backpressure: phy_ready_i stalls the PHY side; host_ready_o drops when full; a push while full is dropped and overflow_o pulses.
module lcd_instr_sequencer #(
  parameter int INSTR_WIDTH     = 10,
  parameter int PRESCALER_WIDTH = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          phy_enable_i,
  input  logic [PRESCALER_WIDTH-1:0]    us_prescaler_i,
  input  logic [INSTR_WIDTH-1:0]        instr_i,
  input  logic                          instr_valid_i,
  output logic                          host_ready_o,
  output logic                          overflow_o,
  output logic [INSTR_WIDTH-1:0]        phy_instr_o,
  output logic                          phy_valid_o,
  input  logic                          phy_ready_i,
  output logic                          init_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = PRESCALER_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    PWR_WAIT,
    INIT_ISSUE,
    INIT_DELAY,
    RUN
  } state_t;

  state_t          state;
  logic [2:0]      idx;
  logic [13:0]     dly;
  logic [PW-1:0]   us_cnt;
  logic [PW-1:0]   presc_max;
  logic            in_delay;
  logic            tick;
  logic            dly_done;

  logic [INSTR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;

  // Init ROM: instruction half
  function automatic logic [INSTR_WIDTH-1:0] rom_instr(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: rom_instr = INSTR_WIDTH'(10'h030);
      3'd3:             rom_instr = INSTR_WIDTH'(10'h038);
      3'd4:             rom_instr = INSTR_WIDTH'(10'h008);
      3'd5:             rom_instr = INSTR_WIDTH'(10'h001);
      3'd6:             rom_instr = INSTR_WIDTH'(10'h006);
      default:          rom_instr = INSTR_WIDTH'(10'h00C);
    endcase
  endfunction

  // Init ROM: post-issue delay in microseconds
  function automatic logic [13:0] rom_delay(input logic [2:0] i);
    case (i)
      3'd0:       rom_delay = 14'd4100;
      3'd1, 3'd2: rom_delay = 14'd100;
      default:    rom_delay = 14'd0;
    endcase
  endfunction

  // A prescaler of 0 behaves like 1 so the tick still fires every cycle
  assign presc_max = (us_prescaler_i == '0) ? '0 : (us_prescaler_i - PW'(1));
  assign in_delay  = (state == PWR_WAIT) || (state == INIT_DELAY);
  assign tick      = in_delay && (us_cnt >= presc_max);
  assign dly_done  = tick && (dly <= 14'd1);

  // Microsecond prescaler, parked at 0 outside delay states
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      us_cnt <= '0;
    end else if (!phy_enable_i || !in_delay || tick) begin
      us_cnt <= '0;
    end else begin
      us_cnt <= us_cnt + PW'(1);
    end
  end

  // Sequencer FSM: power-up wait, ROM walk, then hand over to the FIFO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      idx   <= 3'd0;
      dly   <= 14'd0;
    end else if (!phy_enable_i) begin
      state <= IDLE;
      idx   <= 3'd0;
      dly   <= 14'd0;
    end else begin
      case (state)
        IDLE: begin
          state <= PWR_WAIT;
          dly   <= 14'd15000;
        end
        PWR_WAIT: begin
          if (tick) dly <= dly - 14'd1;
          if (dly_done) state <= INIT_ISSUE;
        end
        INIT_ISSUE: begin
          if (phy_ready_i) begin
            if (rom_delay(idx) != 14'd0) begin
              state <= INIT_DELAY;
              dly   <= rom_delay(idx);
            end else if (idx == 3'd7) begin
              state <= RUN;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        INIT_DELAY: begin
          if (tick) dly <= dly - 14'd1;
          if (dly_done) begin
            state <= INIT_ISSUE;
            idx   <= idx + 3'd1;
          end
        end
        RUN: state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = phy_enable_i && instr_valid_i && !full;
  assign pop   = phy_enable_i && (state == RUN) && !empty && phy_ready_i;

  // FIFO pointers; disabling the sequencer flushes and ignores that cycle's push
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else if (!phy_enable_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      overflow_o <= instr_valid_i && full;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate every read
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= instr_i;
  end

  assign host_ready_o = !full;
  assign fifo_level_o = wr_ptr - rd_ptr;
  assign init_done_o  = (state == RUN);
  assign phy_valid_o  = (state == INIT_ISSUE) || ((state == RUN) && !empty);
  assign phy_instr_o  = (state == INIT_ISSUE)          ? rom_instr(idx) :
                        ((state == RUN) && !empty)     ? mem[rd_ptr[AW-1:0]] :
                                                         '0;

endmodule

// File: tb/tb_lcd_instr_sequencer.sv
// Directed bench for lcd_instr_sequencer: init timing, stall, FIFO fill/overflow,
// RUN latency, push+pop, disable/flush, re-enable and asynchronous reset.
module tb_lcd_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        phy_enable;
  logic [15:0] us_prescaler;
  logic [9:0]  instr;
  logic        instr_valid;
  logic        host_ready;
  logic        overflow;
  logic [9:0]  phy_instr;
  logic        phy_valid;
  logic        phy_ready;
  logic        init_done;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  lcd_instr_sequencer #(
    .INSTR_WIDTH(10),
    .PRESCALER_WIDTH(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .phy_enable_i(phy_enable),
    .us_prescaler_i(us_prescaler),
    .instr_i(instr),
    .instr_valid_i(instr_valid),
    .host_ready_o(host_ready),
    .overflow_o(overflow),
    .phy_instr_o(phy_instr),
    .phy_valid_o(phy_valid),
    .phy_ready_i(phy_ready),
    .init_done_o(init_done),
    .fifo_level_o(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Step until phy_valid is high or the budget runs out; n = edges taken
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!phy_valid && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; phy_enable = 1'b0; us_prescaler = 16'd2;
    instr = '0; instr_valid = 1'b0; phy_ready = 1'b1;
    #13;
    if (phy_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", phy_valid); end
    checks++;
    if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_host_ready: got %b want 1", host_ready); end
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++;
    if ({overflow, phy_instr} !== 11'h0) begin errors++; $display("FAIL reset_ovf_instr: got %h want 0", {overflow, phy_instr}); end
    checks++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Full init at prescaler 2 with the FIFO pre-filled during the power wait
  task automatic test_init_and_fifo_fill();
    int n, t0;
    int gaps[3];
    logic [9:0] nxt[3];
    logic [9:0] tail[4];
    logic [9:0] exp;
    gaps = '{8200, 200, 200};
    nxt  = '{10'h030, 10'h030, 10'h038};
    tail = '{10'h008, 10'h001, 10'h006, 10'h00C};
    us_prescaler = 16'd2; phy_ready = 1'b1; phy_enable = 1'b1;
    step();
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      instr = 10'h141 + 10'(i); instr_valid = 1'b1;
      step();
    end
    instr_valid = 1'b0;
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d want 4", fifo_level); end
    checks++;
    if (host_ready !== 1'b0) begin errors++; $display("FAIL fill_host_ready: got %b want 0", host_ready); end
    checks++;
    instr = 10'h145; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_pulse: got %b want 1", overflow); end
    checks++;
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL overflow_level: got %0d want 4", fifo_level); end
    checks++;
    step();
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_one_cycle: got %b want 0", overflow); end
    checks++;
    wait_valid(40000, n);
    if (cyc - t0 !== 30000) begin errors++; $display("FAIL pwr_wait_len: got %0d want 30000", cyc - t0); end
    checks++;
    if (phy_instr !== 10'h030) begin errors++; $display("FAIL first_instr: got %h want 030", phy_instr); end
    checks++;
    for (int k = 0; k < 3; k++) begin
      step();
      wait_valid(10000, n);
      if (n !== gaps[k]) begin errors++; $display("FAIL init_gap%0d: got %0d want %0d", k, n, gaps[k]); end
      checks++;
      if (phy_instr !== nxt[k]) begin errors++; $display("FAIL init_after_gap%0d: got %h want %h", k, phy_instr, nxt[k]); end
      checks++;
    end
    for (int k = 0; k < 4; k++) begin
      step();
      if ({phy_valid, init_done, phy_instr} !== {2'b10, tail[k]}) begin
        errors++; $display("FAIL init_tail%0d: got %h want %h", k, {phy_valid, init_done, phy_instr}, {2'b10, tail[k]});
      end
      checks++;
    end
    step();
    if (init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %b want 1", init_done); end
    checks++;
    for (int k = 0; k < 4; k++) begin
      exp = 10'h141 + 10'(k);
      if ({phy_valid, phy_instr} !== {1'b1, exp}) begin
        errors++; $display("FAIL drain%0d: got %h want %h", k, {phy_valid, phy_instr}, {1'b1, exp});
      end
      checks++;
      step();
    end
    if ({phy_valid, fifo_level} !== 4'b0_000) begin errors++; $display("FAIL drain_empty: got %b want 0000", {phy_valid, fifo_level}); end
    checks++;
  endtask

  task automatic test_run_latency();
    phy_ready = 1'b1;
    instr = 10'h080; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    if ({phy_valid, phy_instr} !== {1'b1, 10'h080}) begin errors++; $display("FAIL run_latency: got %h want %h", {phy_valid, phy_instr}, {1'b1, 10'h080}); end
    checks++;
    step();
    if ({phy_valid, fifo_level} !== 4'b0_000) begin errors++; $display("FAIL run_pop: got %b want 0000", {phy_valid, fifo_level}); end
    checks++;
  endtask

  task automatic test_push_pop_same_cycle();
    phy_ready = 1'b0;
    instr = 10'h0A1; instr_valid = 1'b1; step();
    instr = 10'h0A2; step();
    if ({fifo_level, phy_instr} !== {3'd2, 10'h0A1}) begin errors++; $display("FAIL pp_prefill: got %h want %h", {fifo_level, phy_instr}, {3'd2, 10'h0A1}); end
    checks++;
    phy_ready = 1'b1; instr = 10'h0A3;
    step();
    instr_valid = 1'b0;
    if ({fifo_level, phy_instr} !== {3'd2, 10'h0A2}) begin errors++; $display("FAIL pp_same_cycle: got %h want %h", {fifo_level, phy_instr}, {3'd2, 10'h0A2}); end
    checks++;
    step();
    if ({fifo_level, phy_instr} !== {3'd1, 10'h0A3}) begin errors++; $display("FAIL pp_order: got %h want %h", {fifo_level, phy_instr}, {3'd1, 10'h0A3}); end
    checks++;
    step();
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL pp_empty: got %0d want 0", fifo_level); end
    checks++;
  endtask

  // Restart with prescaler 0 (acts as 1), then disable during the first post-delay
  task automatic test_disable_mid_init();
    int n, t0;
    phy_enable = 1'b0; us_prescaler = 16'd0;
    step();
    if (init_done !== 1'b0) begin errors++; $display("FAIL disable_from_run: got %b want 0", init_done); end
    checks++;
    phy_enable = 1'b1;
    step();
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      instr = 10'h111 + 10'(i); instr_valid = 1'b1; step();
    end
    instr_valid = 1'b0;
    wait_valid(20000, n);
    if (cyc - t0 !== 15000) begin errors++; $display("FAIL p0_pwr_wait: got %0d want 15000", cyc - t0); end
    checks++;
    step();
    for (int i = 0; i < 10; i++) step();
    if ({phy_valid, fifo_level} !== 4'b0_100) begin errors++; $display("FAIL in_delay: got %b want 0100", {phy_valid, fifo_level}); end
    checks++;
    phy_enable = 1'b0; instr = 10'h1FF; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    if ({phy_valid, init_done, fifo_level, host_ready, overflow} !== 7'b00_000_10) begin
      errors++; $display("FAIL disable_flush: got %b want 0000010", {phy_valid, init_done, fifo_level, host_ready, overflow});
    end
    checks++;
    step();
    if ({phy_valid, fifo_level} !== 4'b0_000) begin errors++; $display("FAIL idle_hold: got %b want 0000", {phy_valid, fifo_level}); end
    checks++;
  endtask

  task automatic test_reenable_stall();
    int n, t0;
    int gaps[3];
    gaps = '{4100, 100, 100};
    phy_ready = 1'b1; phy_enable = 1'b1;
    step();
    t0 = cyc;
    wait_valid(20000, n);
    if (cyc - t0 !== 15000) begin errors++; $display("FAIL restart_wait: got %0d want 15000", cyc - t0); end
    checks++;
    if (phy_instr !== 10'h030) begin errors++; $display("FAIL restart_instr: got %h want 030", phy_instr); end
    checks++;
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 2) phy_ready = 1'b0;
      wait_valid(5000, n);
      if (n !== gaps[k]) begin errors++; $display("FAIL p0_gap%0d: got %0d want %0d", k, n, gaps[k]); end
      checks++;
    end
    for (int i = 0; i < 50; i++) begin
      if ({phy_valid, phy_instr} !== {1'b1, 10'h038}) begin
        errors++; $display("FAIL stall_hold%0d: got %h want %h", i, {phy_valid, phy_instr}, {1'b1, 10'h038});
      end
      checks++;
      step();
    end
    phy_ready = 1'b1;
    step();
    if (phy_instr !== 10'h008) begin errors++; $display("FAIL stall_release: got %h want 008", phy_instr); end
    checks++;
    for (int i = 0; i < 4; i++) step();
    if (init_done !== 1'b1) begin errors++; $display("FAIL reinit_done: got %b want 1", init_done); end
    checks++;
  endtask

  task automatic test_async_reset();
    phy_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      instr = 10'h155 + 10'(i); instr_valid = 1'b1; step();
    end
    instr_valid = 1'b0;
    if ({phy_valid, host_ready, fifo_level} !== 5'b10_100) begin errors++; $display("FAIL pre_reset: got %b want 10100", {phy_valid, host_ready, fifo_level}); end
    checks++;
    #2;
    rst_n = 1'b0;
    #1;
    if ({phy_valid, init_done, host_ready, overflow, fifo_level, phy_instr} !== {4'b0010, 3'd0, 10'h000}) begin
      errors++; $display("FAIL async_reset: got %h want %h", {phy_valid, init_done, host_ready, overflow, fifo_level, phy_instr}, {4'b0010, 3'd0, 10'h000});
    end
    checks++;
    step();
    rst_n = 1'b1; phy_enable = 1'b0;
    step();
    if ({phy_valid, fifo_level} !== 4'b0_000) begin errors++; $display("FAIL post_reset: got %b want 0000", {phy_valid, fifo_level}); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_init_and_fifo_fill();
    test_run_latency();
    test_push_pop_same_cycle();
    test_disable_mid_init();
    test_reenable_stall();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
